alu_req_driver: RTL

Synthesizable initiator for the ALU request/result interface: it takes transaction descriptors (opcode, operand-select, operands, pre-issue delay) from an upstream source, such as the chromosome-driven generator or a stimulus ROM. It drives them onto the ALU input handshake and counts returned results. It is the hardware counterpart of the ALU's receiving side and lets a run of TRANS_NUM transactions per chromosome execute in emulation without the UVM driver.

---
 rtl/alu_hw_pkg.sv | 31 +++
 rtl/alu_res_counter.sv | 63 ++++++
 rtl/alu_req_driver.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/alu_hw_pkg.sv
// Shared ALU hardware types: driver FSM states, MOVI encodings and the request descriptor.
package alu_hw_pkg;

  localparam int unsigned OP_WIDTH        = 4;
  localparam int unsigned MOVI_WIDTH      = 2;
  localparam int unsigned REQ_DATA_WIDTH  = 8;
  localparam int unsigned REQ_DELAY_WIDTH = 4;

  localparam logic [MOVI_WIDTH-1:0] MOVI_REG = 2'b00;
  localparam logic [MOVI_WIDTH-1:0] MOVI_MEM = 2'b01;
  localparam logic [MOVI_WIDTH-1:0] MOVI_IMM = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_WAIT,
    ST_DRIVE,
    ST_DRAIN
  } alu_state_e;

  typedef struct packed {
    logic [OP_WIDTH-1:0]        op;
    logic [MOVI_WIDTH-1:0]      movi;
    logic [REQ_DATA_WIDTH-1:0]  a;
    logic [REQ_DATA_WIDTH-1:0]  b;
    logic [REQ_DATA_WIDTH-1:0]  mem;
    logic [REQ_DATA_WIDTH-1:0]  imm;
    logic [REQ_DELAY_WIDTH-1:0] delay;
  } alu_req_t;

endpackage

// File: rtl/alu_res_counter.sv
// Result capture for the ALU request driver: registered result copy, received count
// and sticky detection of results that arrive without an outstanding request.
module alu_res_counter #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic                  active,
  input  logic                  ex_vld,
  input  logic [DATA_WIDTH-1:0] ex_data,
  input  logic [CNT_WIDTH-1:0]  sent_cnt,
  output logic                  res_vld,
  output logic [DATA_WIDTH-1:0] res,
  output logic [CNT_WIDTH-1:0]  recv_cnt,
  output logic                  err
);

  logic                  res_vld_q, res_vld_d;
  logic [DATA_WIDTH-1:0] res_q, res_d;
  logic [CNT_WIDTH-1:0]  recv_q, recv_d;
  logic                  err_q, err_d;

  always_comb begin
    res_vld_d = active && ex_vld;
    res_d     = res_q;
    recv_d    = recv_q;
    err_d     = err_q;
    if (active && ex_vld) begin
      res_d  = ex_data;
      recv_d = recv_q + CNT_WIDTH'(1);
    end
    if (ex_vld && (!active || recv_q >= sent_cnt)) begin
      err_d = 1'b1;
    end
    // A new run starts from a clean slate even if a stray result lands on the START edge.
    if (clear) begin
      recv_d = '0;
      err_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_vld_q <= 1'b0;
      res_q     <= '0;
      recv_q    <= '0;
      err_q     <= 1'b0;
    end else begin
      res_vld_q <= res_vld_d;
      res_q     <= res_d;
      recv_q    <= recv_d;
      err_q     <= err_d;
    end
  end

  assign res_vld  = res_vld_q;
  assign res      = res_q;
  assign recv_cnt = recv_q;
  assign err      = err_q;

endmodule

// File: rtl/alu_req_driver.sv
// Initiator for the ALU request/result interface: fetches descriptors, waits their
// pre-issue delay, drives them with ACT/ALU_RDY handshake and tracks completion of a run.
module alu_req_driver
  import alu_hw_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned DELAY_WIDTH = 4,
  parameter int unsigned CNT_WIDTH   = 16
) (
  input  logic                   CLK,
  input  logic                   RST_N,
  input  logic                   START,
  input  logic [CNT_WIDTH-1:0]   TRANS_NUM,
  input  logic                   IN_VLD,
  output logic                   IN_RDY,
  input  logic [3:0]             IN_OP,
  input  logic [1:0]             IN_MOVI,
  input  logic [DATA_WIDTH-1:0]  IN_A,
  input  logic [DATA_WIDTH-1:0]  IN_B,
  input  logic [DATA_WIDTH-1:0]  IN_MEM,
  input  logic [DATA_WIDTH-1:0]  IN_IMM,
  input  logic [DELAY_WIDTH-1:0] IN_DELAY,
  output logic                   ACT,
  output logic [3:0]             OP,
  output logic [1:0]             MOVI,
  output logic [DATA_WIDTH-1:0]  REG_A,
  output logic [DATA_WIDTH-1:0]  REG_B,
  output logic [DATA_WIDTH-1:0]  MEM,
  output logic [DATA_WIDTH-1:0]  IMM,
  input  logic                   ALU_RDY,
  input  logic                   EX_ALU_VLD,
  input  logic [DATA_WIDTH-1:0]  EX_ALU,
  output logic                   RES_VLD,
  output logic [DATA_WIDTH-1:0]  RES,
  output logic [CNT_WIDTH-1:0]   SENT_CNT,
  output logic [CNT_WIDTH-1:0]   RECV_CNT,
  output logic                   BUSY,
  output logic                   DONE,
  output logic                   ERR
);

  alu_state_e           state_q, state_d;
  alu_req_t             req_q, req_d;
  logic [CNT_WIDTH-1:0] target_q, target_d;
  logic [CNT_WIDTH-1:0] sent_q, sent_d;
  logic                 done_q, done_d;
  logic                 start_run;
  logic [CNT_WIDTH-1:0] recv_cnt;

  // The descriptor's delay field doubles as the pre-issue countdown.
  always_comb begin
    state_d   = state_q;
    req_d     = req_q;
    target_d  = target_q;
    sent_d    = sent_q;
    done_d    = 1'b0;
    start_run = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (START) begin
          start_run = 1'b1;
          target_d  = TRANS_NUM;
          sent_d    = '0;
          state_d   = (TRANS_NUM == '0) ? ST_DRAIN : ST_FETCH;
        end
      end
      ST_FETCH: begin
        if (IN_VLD) begin
          req_d = '{op: IN_OP, movi: IN_MOVI, a: IN_A, b: IN_B,
                    mem: IN_MEM, imm: IN_IMM, delay: IN_DELAY};
          state_d = (IN_DELAY != '0) ? ST_WAIT : ST_DRIVE;
        end
      end
      ST_WAIT: begin
        req_d.delay = req_q.delay - REQ_DELAY_WIDTH'(1);
        if (req_q.delay == REQ_DELAY_WIDTH'(1)) begin
          state_d = ST_DRIVE;
        end
      end
      ST_DRIVE: begin
        if (ALU_RDY) begin
          sent_d  = sent_q + CNT_WIDTH'(1);
          state_d = (sent_d < target_q) ? ST_FETCH : ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (recv_cnt == target_q) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q  <= ST_IDLE;
      req_q    <= '0;
      target_q <= '0;
      sent_q   <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      req_q    <= req_d;
      target_q <= target_d;
      sent_q   <= sent_d;
      done_q   <= done_d;
    end
  end

  alu_res_counter #(
    .DATA_WIDTH(DATA_WIDTH),
    .CNT_WIDTH (CNT_WIDTH)
  ) u_res_counter (
    .clk     (CLK),
    .rst_n   (RST_N),
    .clear   (start_run),
    .active  (BUSY),
    .ex_vld  (EX_ALU_VLD),
    .ex_data (EX_ALU),
    .sent_cnt(sent_q),
    .res_vld (RES_VLD),
    .res     (RES),
    .recv_cnt(recv_cnt),
    .err     (ERR)
  );

  assign IN_RDY   = (state_q == ST_FETCH);
  assign ACT      = (state_q == ST_DRIVE);
  assign BUSY     = (state_q != ST_IDLE);
  assign DONE     = done_q;
  assign SENT_CNT = sent_q;
  assign RECV_CNT = recv_cnt;

  assign OP    = ACT ? req_q.op   : '0;
  assign MOVI  = ACT ? req_q.movi : '0;
  assign REG_A = ACT ? req_q.a    : '0;
  assign REG_B = ACT ? req_q.b    : '0;
  assign MEM   = ACT ? req_q.mem  : '0;
  assign IMM   = ACT ? req_q.imm  : '0;

endmodule
